block_datapath: RTL
===================

# block_datapath

Datapath partner of the block-stacker control FSM. It holds the moving block's position and raster-scans the block's pixels for the VGA adapter, driving either the block colour or black. It runs the frame-delay counter and bounces the block horizontally between the screen edges. It returns `done_plot` and `enable_erase` to the controller and consumes every control strobe the controller issues.

## Interface
- `BLOCK_W`, 16: block width in pixels; power of two, ≥2.
- `BLOCK_H`, 4: block height in pixels; power of two, ≥1.
- `X_MAX`, 160: screen width; the block occupies columns `bx .. bx+BLOCK_W-1`, all < X_MAX.
- `START_Y`, 116: row of the block's top edge after reset.
- `DELAY`, 833333: frame delay in clk cycles, ≥2.
- `DELAY_W`, 20: delay counter width; must satisfy 2^DELAY_W ≥ DELAY.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `reset_load` in 1: sync active-low; re-initialises position, direction and pixel counters.
- `reset_counter` in 1: sync active-low; clears the delay counter.
- `enable_counter` in 1: advances the delay counter.
- `ld_x` in 1: step the block one pixel horizontally.
- `ld_y` in 1: apply a row step when `row_up` is high.
- `row_up` in 1: qualifies `ld_y`; the block rises by BLOCK_H.
- `count_x_enable` in 1: advances the pixel raster by one pixel.
- `colour_erase_enable` in 1: forces the output colour to black.
- `colour_in` in 3: block colour.
- `x_out` out 8: pixel x = bx + cx.
- `y_out` out 7: pixel y = by + cy.
- `colour_out` out 3: `colour_erase_enable ? 3'b000 : colour_in`.
- `done_plot` out 1: last pixel of the raster is being presented.
- `enable_erase` out 1: frame delay has expired.

## Operation
State registers:
- `bx` [7:0]: block x position.
- `by` [6:0]: block y position.
- `dir`: 0 = right, 1 = left.
- `cx` [log2 BLOCK_W-1:0] and `cy` [log2 BLOCK_H-1:0]: pixel raster counters.
- `dcnt` [DELAY_W-1:0]: delay counter.

Reset:
- `resetn` low or `reset_load` low sets bx=0, by=START_Y, dir=0, cx=0, cy=0.
- `resetn` low or `reset_counter` low sets dcnt=0.
- Both resets override all other inputs in the same cycle.

Raster:
- When `count_x_enable` is high, cx increments each cycle.
- At cx=BLOCK_W-1, cx wraps to 0 and cy increments.
- At cx=BLOCK_W-1 and cy=BLOCK_H-1, both counters wrap to 0. The counters are therefore zero for the next PLOT or ERASE pass.
- When `count_x_enable` is low, cx and cy hold.
- `done_plot = count_x_enable & (cx==BLOCK_W-1) & (cy==BLOCK_H-1)`, combinational.

Movement, on `ld_x`:
- dir=0 and bx+BLOCK_W == X_MAX: set dir=1 and bx=bx-1.
- dir=0 otherwise: bx=bx+1.
- dir=1 and bx==0: set dir=0 and bx=1.
- dir=1 otherwise: bx=bx-1.
- bx never leaves the range 0..X_MAX-BLOCK_W.

Row step:
- `ld_y & row_up` sets by = by-BLOCK_H, saturating at 0.
- `ld_y` without `row_up` holds by.
- When `ld_x` and `ld_y` are both high, both updates apply in the same cycle.

Delay counter:
- When `enable_counter` is high and dcnt < DELAY-1, dcnt increments.
- dcnt saturates at DELAY-1.
- `enable_erase = enable_counter & (dcnt==DELAY-1)`, combinational.

Arithmetic:
- x_out and y_out are combinational sums truncated to 8 and 7 bits.
- Valid parameters guarantee no overflow.

Illegal and mid-operation cases:
- `ld_x`, `ld_y` or `row_up` high while `count_x_enable` is high is illegal use. Position updates apply anyway, and the outputs follow the new bx/by immediately.
- A reset asserted in the middle of a raster restarts the raster at pixel (0,0).

## Timing
- Values after any reset: x_out=0, y_out=START_Y, colour_out=colour_in (or 0 while erasing), done_plot=0, enable_erase=0.
- A raster pass takes exactly BLOCK_W·BLOCK_H cycles of `count_x_enable`. `done_plot` is high during the final cycle only, so the controller leaves PLOT/ERASE on the edge that writes the last pixel.
- After `reset_counter` has been low for one cycle, `enable_erase` first rises in the DELAY-th cycle of `enable_counter` high.
- Position updates are visible on x_out/y_out in the cycle after the `ld_x`/`ld_y` edge.
- No output is registered. All outputs are combinational from state plus the current control inputs.

## Test plan
Parameters for all scenarios: BLOCK_W=4, BLOCK_H=2, X_MAX=8, START_Y=10, DELAY=5.
- Reset, then hold `count_x_enable` high for 8 cycles -> (x,y) sequence is (0,10)(1,10)(2,10)(3,10)(0,11)(1,11)(2,11)(3,11); `done_plot` is high only in the 8th cycle; the 9th cycle shows (0,10).
- Pulse `ld_x` 10 times from reset -> bx goes 1,2,3,4,3,2,1,0,1,2; dir flips at bx=4 and at bx=0.
- Pulse `reset_counter` low, then hold `enable_counter` high -> `enable_erase` rises in cycle 5 and stays high while enable is held; dropping enable drops it.
- Raise `colour_erase_enable` with colour_in=3'b101 -> colour_out=000; lower it -> 101 in the same cycle.
- `ld_y` with `row_up` high 4 times from by=10 -> by goes 8,6,4,2; `ld_y` with `row_up` low -> by holds.
- Assert `reset_load` low at the 5th raster pixel with bx=3 -> next cycle shows (0,10); the raster restarts from its first pixel.

Source files
------------

// File: rtl/block_datapath_if.sv
// Control strobes from the block-stacker controller and the pixel/status
// results returned by the datapath.
interface block_datapath_if;
    logic       reset_load;
    logic       reset_counter;
    logic       enable_counter;
    logic       ld_x;
    logic       ld_y;
    logic       row_up;
    logic       count_x_enable;
    logic       colour_erase_enable;
    logic [2:0] colour_in;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       done_plot;
    logic       enable_erase;

    modport master (
        output reset_load, reset_counter, enable_counter, ld_x, ld_y, row_up,
               count_x_enable, colour_erase_enable, colour_in,
        input  x_out, y_out, colour_out, done_plot, enable_erase
    );

    modport slave (
        input  reset_load, reset_counter, enable_counter, ld_x, ld_y, row_up,
               count_x_enable, colour_erase_enable, colour_in,
        output x_out, y_out, colour_out, done_plot, enable_erase
    );
endinterface

// File: rtl/block_datapath.sv
// Block-stacker datapath: holds the moving block position, raster-scans its
// pixels for the VGA adapter, bounces it between the screen edges and runs
// the frame-delay counter. All outputs are combinational.
module block_datapath #(
    parameter int BLOCK_W = 16,
    parameter int BLOCK_H = 4,
    parameter int X_MAX   = 160,
    parameter int START_Y = 116,
    parameter int DELAY   = 833333,
    parameter int DELAY_W = 20
) (
    input  logic            clk,
    input  logic            resetn,
    block_datapath_if.slave bus
);
    localparam int CX_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int CY_W = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

    localparam logic [CX_W-1:0]    CX_LAST = CX_W'(BLOCK_W - 1);
    localparam logic [CY_W-1:0]    CY_LAST = CY_W'(BLOCK_H - 1);
    localparam logic [CX_W-1:0]    CX_ONE  = CX_W'(1);
    localparam logic [CY_W-1:0]    CY_ONE  = CY_W'(1);
    // Rightmost legal left edge: bx + BLOCK_W == X_MAX.
    localparam logic [7:0]         BX_LAST = 8'(X_MAX - BLOCK_W);
    localparam logic [6:0]         Y_START = 7'(START_Y);
    localparam logic [6:0]         Y_STEP  = 7'(BLOCK_H);
    localparam logic [DELAY_W-1:0] D_LAST  = DELAY_W'(DELAY - 1);
    localparam logic [DELAY_W-1:0] D_ONE   = DELAY_W'(1);

    logic [7:0]         bx;
    logic [6:0]         by;
    logic               dir;
    logic [CX_W-1:0]    cx;
    logic [CY_W-1:0]    cy;
    logic [DELAY_W-1:0] dcnt;

    logic load_rst;
    logic count_rst;

    assign load_rst  = !resetn || !bus.reset_load;
    assign count_rst = !resetn || !bus.reset_counter;

    // Block position and bounce direction; x and y steps may coincide.
    always_ff @(posedge clk) begin
        if (load_rst) begin
            bx  <= 8'd0;
            by  <= Y_START;
            dir <= 1'b0;
        end else begin
            if (bus.ld_x) begin
                if (!dir) begin
                    if (bx == BX_LAST) begin
                        dir <= 1'b1;
                        bx  <= bx - 8'd1;
                    end else begin
                        bx  <= bx + 8'd1;
                    end
                end else begin
                    if (bx == 8'd0) begin
                        dir <= 1'b0;
                        bx  <= 8'd1;
                    end else begin
                        bx  <= bx - 8'd1;
                    end
                end
            end
            if (bus.ld_y && bus.row_up) begin
                by <= (by >= Y_STEP) ? (by - Y_STEP) : 7'd0;
            end
        end
    end

    // Pixel raster; wraps to (0,0) after the last pixel so every pass starts clean.
    always_ff @(posedge clk) begin
        if (load_rst) begin
            cx <= '0;
            cy <= '0;
        end else if (bus.count_x_enable) begin
            if (cx == CX_LAST) begin
                cx <= '0;
                cy <= (cy == CY_LAST) ? '0 : (cy + CY_ONE);
            end else begin
                cx <= cx + CX_ONE;
            end
        end
    end

    // Frame-delay counter, saturating at its terminal count.
    always_ff @(posedge clk) begin
        if (count_rst) begin
            dcnt <= '0;
        end else if (bus.enable_counter && (dcnt < D_LAST)) begin
            dcnt <= dcnt + D_ONE;
        end
    end

    // Pixel address, colour and status strobes straight from state and inputs.
    always_comb begin
        bus.x_out        = bx + 8'(cx);
        bus.y_out        = by + 7'(cy);
        bus.colour_out   = bus.colour_erase_enable ? 3'b000 : bus.colour_in;
        bus.done_plot    = bus.count_x_enable && (cx == CX_LAST) && (cy == CY_LAST);
        bus.enable_erase = bus.enable_counter && (dcnt == D_LAST);
    end
endmodule
